// File: rtl/matrix_column_loader_if.sv
// Host write port and display column-load port of the matrix column loader.
// The loader itself uses the slave view; the host/control side uses the master view.
interface matrix_column_loader_if #(
   parameter int AW = 6,
   parameter int CW = 5,
   parameter int DW = 16
);
   logic          msg_we;
   logic [AW-1:0] msg_addr;
   logic [DW-1:0] msg_data;
   logic          enable;
   logic [CW-1:0] column_id;
   logic [DW-1:0] in_column;
   logic          load;
   logic          busy;
   logic          frame_done;
   logic [AW-1:0] offset;

   modport master (
      output msg_we, msg_addr, msg_data, enable,
      input  column_id, in_column, load, busy, frame_done, offset
   );

   modport slave (
      input  msg_we, msg_addr, msg_data, enable,
      output column_id, in_column, load, busy, frame_done, offset
   );
endinterface

// File: rtl/matrix_column_loader.sv
// Streams a scrolling window of a host-filled message buffer into a 32-column dot-matrix display,
// one SETUP/STROBE/GAP sequence per column, one full frame per scroll tick.
module matrix_column_loader #(
   parameter int          COLS       = 32,
   parameter int          MSG_LEN    = 64,
   parameter int unsigned SCROLL_DIV = 24'd6000000,
   parameter int          SETUP_CYC  = 2,
   parameter int          HOLD_CYC   = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   matrix_column_loader_if.slave bus
);
   localparam int AW = 6;
   localparam int CW = 5;
   localparam int DW = 16;
   localparam int NW = 8;
   localparam int TW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

   localparam logic [TW-1:0] TICK_LAST  = TW'(SCROLL_DIV - 1);
   localparam logic [AW:0]   MSG_LEN_W  = (AW+1)'(MSG_LEN);
   localparam logic [AW-1:0] OFF_LAST   = AW'(MSG_LEN - 1);
   localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
   localparam logic [NW-1:0] SETUP_LAST = NW'(SETUP_CYC - 1);
   localparam logic [NW-1:0] HOLD_LAST  = NW'(HOLD_CYC - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_GAP,
      ST_DONE
   } state_e;

   state_e          state_q, state_d;
   logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
   logic            tick;
   logic            pending_q, pending_d;
   logic [NW-1:0]   cyc_q, cyc_d;
   logic [CW-1:0]   col_q, col_d;
   logic [AW-1:0]   base_q, base_d;
   logic [AW-1:0]   offset_q, offset_d;
   logic [CW-1:0]   column_id_q, column_id_d;
   logic [DW-1:0]   in_column_q, in_column_d;
   logic            load_q, load_d;
   logic            busy_q, busy_d;
   logic            frame_done_q, frame_done_d;
   logic            frame_start;
   logic            enter_setup;
   logic [AW:0]     rd_sum;
   logic [AW-1:0]   rd_addr;

   logic [DW-1:0]      buf_q [MSG_LEN];
   logic [MSG_LEN-1:0] wr_sel;
   logic               wr_en;

   // Out-of-range host addresses are dropped rather than aliased onto a real entry.
   assign wr_en = bus.msg_we && (32'(bus.msg_addr) < MSG_LEN);

   generate
      for (genvar gi = 0; gi < MSG_LEN; gi++) begin : g_wr_sel
         assign wr_sel[gi] = wr_en && (bus.msg_addr == AW'(gi));
      end
   endgenerate

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < MSG_LEN; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < MSG_LEN; i++) begin
            if (wr_sel[i]) begin
               buf_q[i] <= bus.msg_data;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         tick_cnt_q   <= '0;
         pending_q    <= 1'b0;
         cyc_q        <= '0;
         col_q        <= '0;
         base_q       <= '0;
         offset_q     <= '0;
         column_id_q  <= '0;
         in_column_q  <= '0;
         load_q       <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         tick_cnt_q   <= tick_cnt_d;
         pending_q    <= pending_d;
         cyc_q        <= cyc_d;
         col_q        <= col_d;
         base_q       <= base_d;
         offset_q     <= offset_d;
         column_id_q  <= column_id_d;
         in_column_q  <= in_column_d;
         load_q       <= load_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_comb begin
      tick       = (tick_cnt_q == TICK_LAST);
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
   end

   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      col_d       = col_q;
      base_d      = base_q;
      offset_d    = offset_q;
      column_id_d = column_id_q;
      in_column_d = in_column_q;
      frame_start = 1'b0;
      enter_setup = 1'b0;
      rd_sum      = '0;
      rd_addr     = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (pending_q) begin
               frame_start = 1'b1;
               enter_setup = 1'b1;
               base_d      = offset_q;
               col_d       = '0;
               cyc_d       = '0;
               state_d     = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (cyc_q == SETUP_LAST) begin
               cyc_d   = '0;
               state_d = ST_STROBE;
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         ST_STROBE: begin
            if (cyc_q == HOLD_LAST) begin
               cyc_d   = '0;
               state_d = ST_GAP;
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         ST_GAP: begin
            if (col_q == COL_LAST) begin
               state_d = ST_DONE;
            end else begin
               enter_setup = 1'b1;
               col_d       = col_q + 1'b1;
               cyc_d       = '0;
               state_d     = ST_SETUP;
            end
         end
         ST_DONE: begin
            offset_d = (offset_q == OFF_LAST) ? '0 : offset_q + 1'b1;
            state_d  = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // COLS <= MSG_LEN, so a single conditional subtract always lands back in range.
      rd_sum  = {1'b0, base_d} + (AW+1)'(col_d);
      rd_addr = (rd_sum >= MSG_LEN_W) ? AW'(rd_sum - MSG_LEN_W) : AW'(rd_sum);

      // Buffer is sampled only here; a host write on this same edge is seen next frame.
      if (enter_setup) begin
         column_id_d = col_d;
         in_column_d = buf_q[rd_addr];
      end
   end

   always_comb begin
      load_d       = (state_d == ST_STROBE);
      busy_d       = (state_d != ST_IDLE);
      frame_done_d = (state_d == ST_DONE);
   end

   // A frame in flight never clears the request; only its own start does.
   always_comb begin
      if (!bus.enable) begin
         pending_d = 1'b0;
      end else if (tick) begin
         pending_d = 1'b1;
      end else if (frame_start) begin
         pending_d = 1'b0;
      end else begin
         pending_d = pending_q;
      end
   end

   assign bus.column_id  = column_id_q;
   assign bus.in_column  = in_column_q;
   assign bus.load       = load_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = frame_done_q;
   assign bus.offset     = offset_q;

endmodule

// File: tb/tb_matrix_column_loader.sv
// Self-checking bench for matrix_column_loader: per-column scoreboard, timing monitor, table checks.
module tb_matrix_column_loader;
   localparam int COLS      = 32;
   localparam int MSG_LEN   = 64;
   localparam int FRAME_LEN = 161;

   typedef struct {
      logic [4:0]  id;
      logic [15:0] data;
   } sb_t;

   typedef struct {
      int          epoch;
      int          base;
      int          col;
      logic [15:0] exp;
   } tv_t;

   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic rst2 = 1'b1;
   always #5 clk = ~clk;

   matrix_column_loader_if bus ();
   matrix_column_loader_if bus2 ();

   matrix_column_loader #(.SCROLL_DIV(200)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   // Scroll period one cycle longer than a frame: the next tick lands on the DONE cycle.
   matrix_column_loader #(.SCROLL_DIV(162)) dut2 (
      .clk_i (clk),
      .rst_i (rst2),
      .bus   (bus2)
   );

   int          vectors     = 0;
   int          miscompares = 0;
   sb_t         sb_q[$];
   logic [15:0] mem [MSG_LEN];
   logic [15:0] cap [COLS];
   tv_t         tv [10];
   int          exp_offset = 0;
   int          epoch      = 0;
   int          rise_cnt   = 0;
   bit          mon_en     = 1'b0;
   bit          d2_done    = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_column_id"},  32'(bus.column_id),  32'(0));
      check({tag, "_in_column"},  32'(bus.in_column),  32'(0));
      check({tag, "_load"},       32'(bus.load),       32'(0));
      check({tag, "_busy"},       32'(bus.busy),       32'(0));
      check({tag, "_frame_done"}, 32'(bus.frame_done), 32'(0));
      check({tag, "_offset"},     32'(bus.offset),     32'(0));
   endtask

   // LOAD-edge monitor: setup/hold stability, scoreboard pop, busy length.
   initial begin : monitor
      logic        prev_load, prev_busy, h1_load, h2_load;
      logic [4:0]  h1_id, h2_id, r_id;
      logic [15:0] h1_d, h2_d, r_d;
      int          hi_cnt, busy_cnt;
      sb_t         e;
      prev_load = 1'b0; prev_busy = 1'b0; h1_load = 1'b1; h2_load = 1'b1;
      h1_id = '0; h2_id = '0; r_id = '0; h1_d = '0; h2_d = '0; r_d = '0;
      hi_cnt = 0; busy_cnt = 0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            prev_load = 1'b0; prev_busy = 1'b0; h1_load = 1'b1; h2_load = 1'b1;
            hi_cnt = 0; busy_cnt = 0;
         end else begin
            if (bus.load && !prev_load) begin
               rise_cnt++;
               check("setup_stable", 32'(!h1_load && !h2_load &&
                     h1_id == bus.column_id && h2_id == bus.column_id &&
                     h1_d == bus.in_column && h2_d == bus.in_column), 32'(1));
               if (sb_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_load: column_id=%0d in_column=0x%0h with no frame expected",
                           bus.column_id, bus.in_column);
               end else begin
                  e = sb_q.pop_front();
                  check("column_id", 32'(bus.column_id), 32'(e.id));
                  check("in_column", 32'(bus.in_column), 32'(e.data));
               end
               cap[bus.column_id] = bus.in_column;
               r_id   = bus.column_id;
               r_d    = bus.in_column;
               hi_cnt = 1;
            end else if (bus.load) begin
               hi_cnt++;
               check("hold_stable", 32'(r_id == bus.column_id && r_d == bus.in_column), 32'(1));
            end else if (prev_load) begin
               check("hold_cycles", 32'(hi_cnt), 32'(2));
            end
            if (bus.busy) begin
               busy_cnt++;
            end else if (prev_busy) begin
               check("busy_len", 32'(busy_cnt), 32'(FRAME_LEN));
               busy_cnt = 0;
            end
            prev_load = bus.load;
            prev_busy = bus.busy;
            h2_load = h1_load; h2_id = h1_id; h2_d = h1_d;
            h1_load = bus.load; h1_id = bus.column_id; h1_d = bus.in_column;
         end
      end
   end

   task automatic run_frame(input bit collide, input bit drop);
      int         n;
      int         base;
      logic [5:0] a;
      n = 0;
      while (!bus.busy && n < 450) begin
         @(negedge clk);
         n++;
      end
      check("frame_start", 32'(bus.busy), 32'(1));
      if (!bus.busy) return;
      base = exp_offset;
      for (int c = 0; c < COLS; c++) begin
         cap[c] = 'x;
         sb_q.push_back('{id: 5'(c), data: mem[(base + c) % MSG_LEN]});
      end
      if (collide) begin
         // Column 10 enters SETUP 50 edges after the frame-start edge.
         repeat (49) @(posedge clk);
         #1;
         a = 6'((base + 10) % MSG_LEN);
         bus.msg_we = 1'b1; bus.msg_addr = a; bus.msg_data = 16'hBEEF;
         @(posedge clk);
         #1;
         bus.msg_we = 1'b0;
         mem[a] = 16'hBEEF;
         @(negedge clk);
      end
      if (drop) begin
         repeat (60) @(negedge clk);
         bus.enable = 1'b0;
      end
      n = 0;
      while (!bus.frame_done && n < 250) begin
         @(negedge clk);
         n++;
      end
      check("frame_done", 32'(bus.frame_done), 32'(1));
      @(negedge clk);
      check("frame_done_pulse", 32'(bus.frame_done), 32'(0));
      check("busy_clear", 32'(bus.busy), 32'(0));
      exp_offset = (base + 1) % MSG_LEN;
      check("offset", 32'(bus.offset), 32'(exp_offset));
      check("sb_drained", 32'(sb_q.size()), 32'(0));
      for (int i = 0; i < 10; i++) begin
         if (tv[i].epoch == epoch && tv[i].base == base) begin
            check($sformatf("table_b%0d_c%0d", base, tv[i].col), 32'(cap[tv[i].col]), 32'(tv[i].exp));
         end
      end
      $display("frame base=%0d -> offset=%0d col0=0x%0h col31=0x%0h", base, bus.offset, cap[0], cap[31]);
   endtask

   initial begin : dut2_check
      int n;
      while (rst2) @(negedge clk);
      n = 0;
      while (!bus2.frame_done && n < 600) begin
         @(negedge clk);
         n++;
      end
      check("d2_frame_done", 32'(bus2.frame_done), 32'(1));
      @(negedge clk);
      check("d2_idle_gap", 32'(bus2.busy), 32'(0));
      check("d2_offset", 32'(bus2.offset), 32'(1));
      @(negedge clk);
      check("d2_back_to_back", 32'(bus2.busy), 32'(1));
      $display("dut2 tick-during-DONE sequence observed");
      d2_done = 1'b1;
   end

   initial begin : main
      int n, r0;
      bit seen_busy;
      bus.msg_we = 1'b0;  bus.msg_addr = '0;  bus.msg_data = '0;  bus.enable = 1'b0;
      bus2.msg_we = 1'b0; bus2.msg_addr = '0; bus2.msg_data = '0; bus2.enable = 1'b1;
      tv[0] = '{0,  0,  0, 16'h1000};
      tv[1] = '{0,  0, 31, 16'h101F};
      tv[2] = '{0,  5, 10, 16'h100F};
      tv[3] = '{0,  6,  9, 16'hBEEF};
      tv[4] = '{0, 40, 23, 16'h103F};
      tv[5] = '{0, 40, 24, 16'h1000};
      tv[6] = '{0, 63,  0, 16'h103F};
      tv[7] = '{0, 63, 16, 16'hBEEF};
      tv[8] = '{0, 63, 31, 16'h101E};
      tv[9] = '{1,  0,  7, 16'h0000};

      rst = 1'b1; rst2 = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst = 1'b0; rst2 = 1'b0; mon_en = 1'b1;

      for (int k = 0; k < MSG_LEN; k++) begin
         mem[k] = 16'h1000 + 16'(k);
         @(posedge clk);
         #1;
         bus.msg_we = 1'b1; bus.msg_addr = 6'(k); bus.msg_data = mem[k];
      end
      @(posedge clk);
      #1;
      bus.msg_we = 1'b0;
      bus.enable = 1'b1;
      @(negedge clk);

      for (int f = 0; f < MSG_LEN; f++) begin
         run_frame(f == 5, 1'b0);
      end
      check("offset_wrapped", 32'(bus.offset), 32'(0));

      run_frame(1'b0, 1'b1);
      r0 = rise_cnt; seen_busy = 1'b0;
      repeat (450) begin
         @(negedge clk);
         if (bus.busy) seen_busy = 1'b1;
      end
      check("no_load_when_disabled", 32'(rise_cnt - r0), 32'(0));
      check("idle_when_disabled", 32'(seen_busy), 32'(0));

      mon_en = 1'b0;
      bus.enable = 1'b1;
      n = 0;
      while (!(bus.load && bus.column_id == 5'd5) && n < 600) begin
         @(negedge clk);
         n++;
      end
      check("reached_col5_strobe", 32'(bus.load), 32'(1));
      rst = 1'b1;
      #1;
      check_reset_outputs("async_rst");
      sb_q.delete();
      exp_offset = 0;
      epoch = 1;
      for (int k = 0; k < MSG_LEN; k++) mem[k] = 16'h0000;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      mon_en = 1'b1;
      r0 = rise_cnt;
      repeat (150) @(negedge clk);
      check("no_load_after_reset", 32'(rise_cnt - r0), 32'(0));
      run_frame(1'b0, 1'b0);

      n = 0;
      while (!d2_done && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("dut2_finished", 32'(d2_done), 32'(1));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
